// File: rtl/alu_pkg.sv
// Shared definitions for the control decoder and the execute-stage ALU.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Any code with bit 3 set is undefined.
    localparam logic [3:0] ALU_ILLEGAL_MASK = 4'b1000;

    typedef enum logic [3:0] {
        OpAnd = 4'b0000,
        OpOr  = 4'b0001,
        OpAdd = 4'b0010,
        OpSll = 4'b0011,
        OpSub = 4'b0100,
        OpSrl = 4'b0101,
        OpMul = 4'b0110,
        OpXor = 4'b0111
    } alu_op_e;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } alu_state_e;

    function automatic logic is_illegal_op(input logic [3:0] code);
        return (code & ALU_ILLEGAL_MASK) != 4'b0000;
    endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles per product.
module alu_iter_mul
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CNTW = $clog2(XLEN);

    logic            busy_q;
    logic [CNTW-1:0] count_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_step;
    logic            last_step;

    // The final step's partial product is folded in combinationally so that
    // the product is complete on the same edge that done is seen.
    always_comb begin
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step = busy_q && (count_q == CNTW'(XLEN - 1));
        done      = last_step;
        product   = acc_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            count_q  <= '0;
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CNTW'(1);
            if (last_step) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus an iterative MUL, valid/ready on both sides,
// registered result toward writeback.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic            regwrite_control,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            regwrite_out,
    output logic            illegal
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic            accept;
    logic            op_illegal;
    logic            op_is_mul;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic [XLEN-1:0] sc_result;

    logic [4:0]      rd_pend_q;
    logic            rw_pend_q;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            rw_q, rw_d;
    logic            ill_q, ill_d;

    assign op_illegal = is_illegal_op(alu_control);
    assign op_is_mul  = (alu_control == OpMul);
    assign in_ready   = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign mul_start  = accept && op_is_mul;

    always_comb begin
        sc_result = '0;
        case (alu_control)
            OpAnd:   sc_result = op_a & op_b;
            OpOr:    sc_result = op_a | op_b;
            OpAdd:   sc_result = op_a + op_b;
            OpSll:   sc_result = op_a << op_b[SHW-1:0];
            OpSub:   sc_result = op_a - op_b;
            OpSrl:   sc_result = op_a >> op_b[SHW-1:0];
            OpXor:   sc_result = op_a ^ op_b;
            default: sc_result = '0;
        endcase
    end

    alu_iter_mul #(
        .XLEN(XLEN)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (mul_done),
        .product(mul_product)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (mul_start) state_d = StMul;
            StMul:   if (mul_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // accept only happens in StIdle and mul_done only in StMul, so the two loads never collide.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        ill_d       = ill_q;
        if (accept && !op_is_mul) begin
            out_valid_d = 1'b1;
            result_d    = sc_result;
            rd_d        = rd_in;
            rw_d        = regwrite_control && !op_illegal;
            ill_d       = op_illegal;
        end else if (state_q == StMul && mul_done) begin
            out_valid_d = 1'b1;
            result_d    = mul_product;
            rd_d        = rd_pend_q;
            rw_d        = rw_pend_q;
            ill_d       = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_pend_q   <= '0;
            rw_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            ill_q       <= ill_d;
            if (mul_start) begin
                rd_pend_q <= rd_in;
                rw_pend_q <= regwrite_control;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign rd_out       = rd_q;
    assign regwrite_out = rw_q;
    assign illegal      = ill_q;

endmodule
